// File: rtl/pe_code_history_logger_if.sv
// Port bundle for the priority-code history logger: encoder sample in,
// oldest logged entry out with its status.
interface pe_code_history_logger_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  logic [3:0]              code_in;
  logic                    parity_in;
  logic                    clear;
  logic                    out_ready;
  logic                    out_valid;
  logic [3:0]              out_code;
  logic                    out_parity;
  logic [7:0]              seg_out;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic [CNT_W-1:0]        err_count;

  modport master (
    output code_in, parity_in, clear, out_ready,
    input  out_valid, out_code, out_parity, seg_out, count, overflow, err_count
  );

  modport slave (
    input  code_in, parity_in, clear, out_ready,
    output out_valid, out_code, out_parity, seg_out, count, overflow, err_count
  );
endinterface

// File: rtl/pe_code_history_logger.sv
// Debounces the encoder's priority code, logs each new stable code with its
// parity into a small FIFO, and shows the oldest entry as a 7-segment image.
module pe_code_history_logger #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 8,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  pe_code_history_logger_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]       cand;
  logic [3:0]       run;
  logic [3:0]       last;
  logic             last_valid;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      fill;
  logic [4:0]       mem [DEPTH];
  logic [4:0]       head;
  logic             overflow;
  logic [CNT_W-1:0] err_count;

  logic accept;
  logic legal;
  logic do_push;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // accept fires once per stable run, on the STABLE_CYCLES-th matching sample
  assign accept  = (bus.code_in == cand) && (run == 4'(STABLE_CYCLES - 1));
  assign legal   = (bus.code_in >= 4'd1) && (bus.code_in <= 4'd9);
  assign do_push = accept && legal && (!last_valid || (bus.code_in != last));

  assign fill  = wr_ptr - rd_ptr;
  assign full  = (fill == (AW+1)'(DEPTH));
  assign pop   = bus.out_valid && bus.out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still takes the push
  assign wr_en = do_push && (!full || pop);
  assign drop  = do_push && full && !pop;

  assign head           = mem[rd_ptr[AW-1:0]];
  assign bus.count      = fill;
  assign bus.out_valid  = (fill != '0);
  assign bus.out_code   = bus.out_valid ? head[4:1] : 4'd0;
  assign bus.out_parity = bus.out_valid ? head[0] : 1'b0;
  assign bus.seg_out    = bus.out_valid ? {head[0], seg7(head[4:1])} : 8'h40;
  assign bus.overflow   = overflow;
  assign bus.err_count  = err_count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {bus.code_in, bus.parity_in};
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      cand       <= 4'd0;
      run        <= 4'd0;
      last_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (bus.code_in != cand) begin
        cand <= bus.code_in;
        run  <= 4'd1;
      end else if (run < 4'(STABLE_CYCLES)) begin
        run <= run + 4'd1;
      end

      if (accept) begin
        if (legal) begin
          last       <= bus.code_in;
          last_valid <= 1'b1;
        end else begin
          last_valid <= 1'b0;
        end
      end

      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  overflow <= 1'b1;
      // parity errors count on every push attempt, dropped or not
      if (do_push && !bus.parity_in && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_code_history_logger.sv
// Directed bench for the code history logger; expected values worked by hand.
module tb_pe_code_history_logger;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pe_code_history_logger_if #(.DEPTH(8), .CNT_W(8)) bif ();

  pe_code_history_logger #(.STABLE_CYCLES(4), .DEPTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] c, input logic p, input int n);
    bif.code_in   = c;
    bif.parity_in = p;
    tick(n);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bif.code_in   = 4'd0;
    bif.parity_in = 1'b1;
    bif.clear     = 1'b0;
    bif.out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bif.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bif.count); end
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bif.out_valid); end
    checks++; if (bif.out_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", bif.out_code); end
    checks++; if (bif.seg_out !== 8'h40) begin failures++; $display("FAIL reset_seg got=%h exp=40", bif.seg_out); end
    checks++; if (bif.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bif.overflow); end
    checks++; if (bif.err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bif.err_count); end
  endtask

  task automatic test_stable_single();
    do_reset();
    hold(4'd5, 1'b1, 3);
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", bif.out_valid); end
    tick(1);
    checks++; if (bif.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bif.out_valid); end
    checks++; if (bif.out_code !== 4'd5) begin failures++; $display("FAIL single_code got=%0d exp=5", bif.out_code); end
    checks++; if (bif.seg_out !== 8'hED) begin failures++; $display("FAIL single_seg got=%h exp=ed", bif.seg_out); end
    checks++; if (bif.out_parity !== 1'b1) begin failures++; $display("FAIL single_par got=%b exp=1", bif.out_parity); end
    tick(6);
    checks++; if (bif.count !== 4'd1) begin failures++; $display("FAIL single_nodup got=%0d exp=1", bif.count); end
  endtask

  task automatic test_glitch();
    do_reset();
    bif.out_ready = 1'b1;
    hold(4'd3, 1'b1, 3);
    checks++; if (bif.count !== 4'd0) begin failures++; $display("FAIL glitch_mid got=%0d exp=0", bif.count); end
    hold(4'd0, 1'b1, 6);
    checks++; if (bif.count !== 4'd0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", bif.count); end
    checks++; if (bif.seg_out !== 8'h40) begin failures++; $display("FAIL glitch_seg got=%h exp=40", bif.seg_out); end
    hold(4'd12, 1'b0, 6);
    checks++; if (bif.count !== 4'd0) begin failures++; $display("FAIL illegal_count got=%0d exp=0", bif.count); end
    checks++; if (bif.err_count !== 8'd0) begin failures++; $display("FAIL illegal_err got=%0d exp=0", bif.err_count); end
    bif.out_ready = 1'b0;
  endtask

  task automatic test_repeat_after_idle();
    do_reset();
    hold(4'd2, 1'b1, 6);
    hold(4'd0, 1'b1, 6);
    hold(4'd2, 1'b0, 6);
    checks++; if (bif.count !== 4'd2) begin failures++; $display("FAIL idle_count got=%0d exp=2", bif.count); end
    checks++; if (bif.err_count !== 8'd1) begin failures++; $display("FAIL idle_err got=%0d exp=1", bif.err_count); end
    checks++; if (bif.seg_out !== 8'hDB) begin failures++; $display("FAIL idle_seg1 got=%h exp=db", bif.seg_out); end
    bif.out_ready = 1'b1;
    tick(1);
    bif.out_ready = 1'b0;
    checks++; if (bif.out_code !== 4'd2) begin failures++; $display("FAIL idle_code2 got=%0d exp=2", bif.out_code); end
    checks++; if (bif.out_parity !== 1'b0) begin failures++; $display("FAIL idle_par2 got=%b exp=0", bif.out_parity); end
    checks++; if (bif.seg_out !== 8'h5B) begin failures++; $display("FAIL idle_seg2 got=%h exp=5b", bif.seg_out); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int c = 1; c <= 9; c++) hold(4'(c), 1'b1, 5);
    checks++; if (bif.count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", bif.count); end
    checks++; if (bif.overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", bif.overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (bif.out_code !== 4'(i)) begin failures++; $display("FAIL fill_pop%0d got=%0d exp=%0d", i, bif.out_code, i); end
      bif.out_ready = 1'b1;
      tick(1);
      bif.out_ready = 1'b0;
    end
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", bif.out_valid); end
    checks++; if (bif.overflow !== 1'b1) begin failures++; $display("FAIL fill_sticky got=%b exp=1", bif.overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 1; c <= 8; c++) hold(4'(c), 1'b1, 5);
    checks++; if (bif.count !== 4'd8) begin failures++; $display("FAIL b2b_full got=%0d exp=8", bif.count); end
    hold(4'd9, 1'b1, 3);
    bif.out_ready = 1'b1;
    tick(1);
    bif.out_ready = 1'b0;
    checks++; if (bif.count !== 4'd8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", bif.count); end
    checks++; if (bif.overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", bif.overflow); end
    for (int i = 2; i <= 9; i++) begin
      checks++; if (bif.out_code !== 4'(i)) begin failures++; $display("FAIL b2b_pop%0d got=%0d exp=%0d", i, bif.out_code, i); end
      bif.out_ready = 1'b1;
      tick(1);
      bif.out_ready = 1'b0;
    end
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bif.out_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int c = 1; c <= 5; c++) hold(4'(c), (c > 3), 5);
    checks++; if (bif.count !== 4'd5) begin failures++; $display("FAIL clr_pre_count got=%0d exp=5", bif.count); end
    checks++; if (bif.err_count !== 8'd3) begin failures++; $display("FAIL clr_pre_err got=%0d exp=3", bif.err_count); end
    bif.clear = 1'b1;
    tick(1);
    bif.clear = 1'b0;
    checks++; if (bif.count !== 4'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", bif.count); end
    checks++; if (bif.err_count !== 8'd0) begin failures++; $display("FAIL clr_err got=%0d exp=0", bif.err_count); end
    checks++; if (bif.overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", bif.overflow); end
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", bif.out_valid); end
    tick(3);
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL clr_early got=%b exp=0", bif.out_valid); end
    tick(1);
    checks++; if (bif.out_valid !== 1'b1) begin failures++; $display("FAIL clr_relog_valid got=%b exp=1", bif.out_valid); end
    checks++; if (bif.out_code !== 4'd5) begin failures++; $display("FAIL clr_relog_code got=%0d exp=5", bif.out_code); end
  endtask

  initial begin
    test_reset();
    test_stable_single();
    test_glitch();
    test_repeat_after_idle();
    test_fill_overflow();
    test_back_to_back();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
